// File: rtl/lcd_seq_ctrl_if.sv
// Panel-side signal bundle for lcd_seq_ctrl: vsync/button inputs and the
// reset, backlight, driver-enable, mode and busy outputs.
interface lcd_seq_ctrl_if #(
   parameter int MODE_W = 4
);
   logic              lcd_vs;
   logic              btn_next;
   logic              lcd_rst_n;
   logic              lcd_bl;
   logic              drv_en;
   logic [MODE_W-1:0] mode;
   logic              busy;

   modport master (
      input  lcd_vs, btn_next,
      output lcd_rst_n, lcd_bl, drv_en, mode, busy
   );

   modport slave (
      output lcd_vs, btn_next,
      input  lcd_rst_n, lcd_bl, drv_en, mode, busy
   );
endinterface

// File: rtl/lcd_seq_ctrl.sv
// LCD power-up and test-pattern mode sequencer; mode changes land only on vsync frame ticks.
// Optional macro LCD_BL_PWM_EN turns the static RUN backlight into an 8-bit PWM of duty BL_DUTY/256.
module lcd_seq_ctrl #(
   parameter int T_RST_LOW       = 1000,
   parameter int T_RST_WAIT      = 5000,
   parameter int FRAMES_PER_MODE = 60,
   parameter int NUM_MODES       = 4,
   parameter int MODE_W          = 4,
   parameter int BL_DUTY         = 192
) (
   input logic            lcd_clk,
   input logic            sys_rst_n,
   lcd_seq_ctrl_if.master bus
);

   localparam int CNT_MAX = (T_RST_LOW > T_RST_WAIT) ? T_RST_LOW : T_RST_WAIT;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int FRM_W   = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
   localparam bit AUTO_EN = (FRAMES_PER_MODE != 0);

   localparam logic [CNT_W-1:0]  RST_LOW_LAST  = CNT_W'(T_RST_LOW - 1);
   localparam logic [CNT_W-1:0]  RST_WAIT_LAST = CNT_W'(T_RST_WAIT - 1);
   localparam logic [FRM_W-1:0]  FRM_LAST      = AUTO_EN ? FRM_W'(FRAMES_PER_MODE - 1) : '0;
   localparam logic [MODE_W-1:0] MODE_LAST     = MODE_W'(NUM_MODES - 1);

   if (NUM_MODES < 2 || NUM_MODES > 16) begin : g_bad_num_modes
      $error("NUM_MODES must be in 2..16");
   end
   if (BL_DUTY < 0 || BL_DUTY > 255) begin : g_bad_bl_duty
      $error("BL_DUTY must be in 0..255");
   end

`ifdef LCD_BL_PWM_EN
   localparam logic BL_ON_ENTRY = (BL_DUTY != 0);
`else
   localparam logic BL_ON_ENTRY = 1'b1;
`endif

   typedef enum logic [1:0] {
      RST_ASSERT,
      RST_WAIT,
      SYNC,
      RUN
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [FRM_W-1:0]  frame_cnt;
   logic [MODE_W-1:0] mode_q;
   logic              vs_q;
   logic              btn_q;
   logic              frame_tick;
   logic              pending;
   logic              rst_n_q;
   logic              bl_q;
   logic              drv_q;
   logic              busy_q;
`ifdef LCD_BL_PWM_EN
   logic [7:0]        pwm_cnt;
   logic [7:0]        pwm_nxt;
   assign pwm_nxt = pwm_cnt + 8'd1;
`endif

   logic btn_edge;
   logic auto_due;
   logic advance;

   assign btn_edge = btn_next_rise();
   assign auto_due = AUTO_EN && (frame_cnt == FRM_LAST);
   assign advance  = (state == RUN) && frame_tick && (pending || auto_due);

   function automatic logic btn_next_rise();
      return bus.btn_next & ~btn_q;
   endfunction

   // NOTE: every register here uses <= so all updates see the pre-edge values,
   // which is what makes a button edge coincident with a tick wait for the next tick.
   always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= RST_ASSERT;
         cnt        <= '0;
         frame_cnt  <= '0;
         mode_q     <= '0;
         vs_q       <= 1'b1;
         btn_q      <= 1'b0;
         frame_tick <= 1'b0;
         pending    <= 1'b0;
         rst_n_q    <= 1'b0;
         bl_q       <= 1'b0;
         drv_q      <= 1'b0;
         busy_q     <= 1'b1;
`ifdef LCD_BL_PWM_EN
         pwm_cnt    <= '0;
`endif
      end else begin
         vs_q       <= bus.lcd_vs;
         btn_q      <= bus.btn_next;
         frame_tick <= vs_q & ~bus.lcd_vs;

         case (state)
            RST_ASSERT: begin
               if (cnt == RST_LOW_LAST) begin
                  cnt     <= '0;
                  rst_n_q <= 1'b1;
                  state   <= RST_WAIT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RST_WAIT: begin
               if (cnt == RST_WAIT_LAST) begin
                  cnt   <= '0;
                  drv_q <= 1'b1;
                  state <= SYNC;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SYNC: begin
               if (frame_tick) begin
                  frame_cnt <= '0;
                  bl_q      <= BL_ON_ENTRY;
                  busy_q    <= 1'b0;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (frame_tick) begin
                  if (pending || auto_due) begin
                     mode_q    <= (mode_q == MODE_LAST) ? '0 : mode_q + 1'b1;
                     frame_cnt <= '0;
                  end else if (AUTO_EN && frame_cnt != FRM_LAST) begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
`ifdef LCD_BL_PWM_EN
               // lcd_bl tracks the count currently held in pwm_cnt
               pwm_cnt <= pwm_nxt;
               bl_q    <= ({1'b0, pwm_nxt} < 9'(BL_DUTY));
`endif
            end
            default: state <= RST_ASSERT;
         endcase

         // A new edge wins over the clear so it is served on the following tick
         if (state != RUN) begin
            pending <= 1'b0;
         end else if (btn_edge) begin
            pending <= 1'b1;
         end else if (advance) begin
            pending <= 1'b0;
         end
      end
   end

   assign bus.lcd_rst_n = rst_n_q;
   assign bus.lcd_bl    = bl_q;
   assign bus.drv_en    = drv_q;
   assign bus.mode      = mode_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Directed bench for lcd_seq_ctrl: two instances (auto-advance 3 frames, and auto-advance off)
// share clock, reset and vsync; expected modes go through a scoreboard queue per frame.
module tb_lcd_seq_ctrl;
   localparam int MODE_W = 4;
`ifdef LCD_BL_PWM_EN
   localparam int EXP_BL_HIGH = 64;
`else
   localparam int EXP_BL_HIGH = 256;
`endif

   logic lcd_clk   = 1'b0;
   logic sys_rst_n = 1'b0;

   lcd_seq_ctrl_if #(.MODE_W(MODE_W)) bus_a ();
   lcd_seq_ctrl_if #(.MODE_W(MODE_W)) bus_b ();

   lcd_seq_ctrl #(
      .T_RST_LOW(10), .T_RST_WAIT(20), .FRAMES_PER_MODE(3),
      .NUM_MODES(4), .MODE_W(MODE_W), .BL_DUTY(64)
   ) dut_a (
      .lcd_clk  (lcd_clk),
      .sys_rst_n(sys_rst_n),
      .bus      (bus_a.master)
   );

   lcd_seq_ctrl #(
      .T_RST_LOW(10), .T_RST_WAIT(20), .FRAMES_PER_MODE(0),
      .NUM_MODES(4), .MODE_W(MODE_W), .BL_DUTY(64)
   ) dut_b (
      .lcd_clk  (lcd_clk),
      .sys_rst_n(sys_rst_n),
      .bus      (bus_b.master)
   );

   always #5 lcd_clk = ~lcd_clk;

   typedef struct {
      string             tag;
      int                unit;
      logic [MODE_W-1:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One vsync low pulse; the mode change lands two edges after the low level is sampled.
   task automatic frame(input string tag, input int ea, input int eb, input bit btn_a_on_tick);
      exp_t e;
      logic [MODE_W-1:0] act;
      sb.push_back('{tag: {tag, "_a"}, unit: 0, exp: MODE_W'(ea)});
      sb.push_back('{tag: {tag, "_b"}, unit: 1, exp: MODE_W'(eb)});
      @(posedge lcd_clk); #1;
      bus_a.lcd_vs = 1'b0;
      bus_b.lcd_vs = 1'b0;
      @(posedge lcd_clk); #1;
      bus_a.lcd_vs = 1'b1;
      bus_b.lcd_vs = 1'b1;
      if (btn_a_on_tick) bus_a.btn_next = 1'b1;
      repeat (3) @(posedge lcd_clk);
      @(negedge lcd_clk);
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         act = (e.unit == 0) ? bus_a.mode : bus_b.mode;
         check(e.tag, 32'(act), 32'(e.exp));
      end
   endtask

   // Called right after reset release; edges are counted from the release.
   task automatic seq_timing(input string tag);
      int rise_a = -1;
      int rise_b = -1;
      int drv_a  = -1;
      bit busy_low = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge lcd_clk);
         @(negedge lcd_clk);
         if (rise_a < 0 && bus_a.lcd_rst_n === 1'b1) rise_a = cyc;
         if (rise_b < 0 && bus_b.lcd_rst_n === 1'b1) rise_b = cyc;
         if (drv_a < 0 && bus_a.drv_en === 1'b1) drv_a = cyc;
         if (bus_a.busy !== 1'b1 || bus_b.busy !== 1'b1) busy_low = 1'b1;
      end
      check({tag, "_rst_rise_a"}, 32'(rise_a), 32'd10);
      check({tag, "_rst_rise_b"}, 32'(rise_b), 32'd10);
      check({tag, "_drv_rise_a"}, 32'(drv_a), 32'd30);
      check({tag, "_busy_held"}, 32'(busy_low), 32'd0);
      check({tag, "_bl_off_sync"}, 32'(bus_a.lcd_bl), 32'd0);
   endtask

   initial begin
      int bl_high;
      bus_a.lcd_vs   = 1'b1;
      bus_b.lcd_vs   = 1'b1;
      bus_a.btn_next = 1'b0;
      bus_b.btn_next = 1'b0;

      repeat (3) @(posedge lcd_clk);
      @(negedge lcd_clk);
      check("rst_lcd_rst_n", 32'(bus_a.lcd_rst_n), 32'd0);
      check("rst_lcd_bl", 32'(bus_a.lcd_bl), 32'd0);
      check("rst_drv_en", 32'(bus_a.drv_en), 32'd0);
      check("rst_mode", 32'(bus_a.mode), 32'd0);
      check("rst_busy", 32'(bus_a.busy), 32'd1);

      @(posedge lcd_clk); #1;
      sys_rst_n = 1'b1;
      seq_timing("boot");

      // First vsync falling edge moves SYNC -> RUN two edges later
      @(posedge lcd_clk); #1;
      bus_a.lcd_vs = 1'b0;
      bus_b.lcd_vs = 1'b0;
      @(posedge lcd_clk); #1;
      bus_a.lcd_vs = 1'b1;
      bus_b.lcd_vs = 1'b1;
      @(negedge lcd_clk);
      check("sync_busy_before_run", 32'(bus_a.busy), 32'd1);
      @(posedge lcd_clk);
      @(negedge lcd_clk);
      check("run_bl_a", 32'(bus_a.lcd_bl), 32'd1);
      check("run_busy_a", 32'(bus_a.busy), 32'd0);
      check("run_busy_b", 32'(bus_b.busy), 32'd0);
      check("run_mode_a", 32'(bus_a.mode), 32'd0);

      // Auto-advance every 3 ticks with wrap; instance b never auto-advances
      for (int n = 1; n <= 13; n++) frame($sformatf("auto_t%0d", n), (n / 3) % 4, 0, 1'b0);

      // Three button edges within one frame give exactly one advance
      for (int k = 0; k < 3; k++) begin
         @(posedge lcd_clk); #1;
         bus_b.btn_next = 1'b1;
         @(posedge lcd_clk); #1;
         bus_b.btn_next = 1'b0;
      end
      frame("btn_once_t14", 0, 1, 1'b0);
      frame("btn_noqueue_t15", 1, 1, 1'b0);

      // Pending button and auto expiry on the same tick advance by one
      frame("auto_t16", 1, 1, 1'b0);
      frame("auto_t17", 1, 1, 1'b0);
      @(posedge lcd_clk); #1;
      bus_a.btn_next = 1'b1;
      @(posedge lcd_clk); #1;
      bus_a.btn_next = 1'b0;
      frame("btn_and_auto_t18", 2, 1, 1'b0);

      // Edge coincident with a tick is served on the following tick
      frame("coincident_t19", 2, 1, 1'b1);
      bus_a.btn_next = 1'b0;
      frame("coincident_t20", 3, 1, 1'b0);

      // Bring instance b to mode 2 and reset asynchronously mid-cycle
      @(posedge lcd_clk); #1;
      bus_b.btn_next = 1'b1;
      @(posedge lcd_clk); #1;
      bus_b.btn_next = 1'b0;
      frame("pre_reset_t21", 3, 2, 1'b0);
      @(posedge lcd_clk); #2;
      sys_rst_n = 1'b0;
      #1;
      check("async_lcd_rst_n_b", 32'(bus_b.lcd_rst_n), 32'd0);
      check("async_lcd_bl_b", 32'(bus_b.lcd_bl), 32'd0);
      check("async_drv_en_b", 32'(bus_b.drv_en), 32'd0);
      check("async_mode_b", 32'(bus_b.mode), 32'd0);
      check("async_busy_b", 32'(bus_b.busy), 32'd1);
      check("async_mode_a", 32'(bus_a.mode), 32'd0);
      check("async_lcd_bl_a", 32'(bus_a.lcd_bl), 32'd0);

      // Button edge during the power-up sequence must be dropped
      @(posedge lcd_clk); #1;
      bus_a.btn_next = 1'b1;
      @(posedge lcd_clk); #1;
      sys_rst_n = 1'b1;
      seq_timing("restart");
      bus_a.btn_next = 1'b0;
      frame("rerun_entry", 0, 0, 1'b0);
      frame("early_btn_ignored", 0, 0, 1'b0);

      bl_high = 0;
      for (int c = 0; c < 256; c++) begin
         @(posedge lcd_clk);
         @(negedge lcd_clk);
         if (bus_a.lcd_bl === 1'b1) bl_high++;
      end
      check("bl_high_per_256", 32'(bl_high), 32'(EXP_BL_HIGH));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
